// File: rtl/bus_arb_pkg.sv
// Shared types and widths for the pad bus arbiter.
// Owner encoding and counter widths used by bus_arbiter and bus_cycle_timer.
// No logic; constants only.
package bus_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int WAIT_W  = 4;  // wait-state counter, covers WAIT_CYCLES 0..15
  localparam int BURST_W = 8;  // DMA burst counter, covers DMA_MAX_BURST 1..255

endpackage

// File: rtl/bus_cycle_timer.sv
// Bus cycle timer: counts the address clock plus WAIT_CYCLES wait clocks.
// Latency: cyc_final is combinational from the counter; cyc_end = cyc_final && ext_rdy.
// Backpressure: ext_rdy=0 holds the counter on the final clock, repeating it.
// Ports: clk, reset_n (async active-low), ext_rdy in; cyc_final, cyc_end out.
module bus_cycle_timer
  import bus_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ext_rdy,
  output logic cyc_final,
  output logic cyc_end
);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign cyc_final = (wait_cnt_q == WAIT_W'(WAIT_CYCLES));
  assign cyc_end   = cyc_final && ext_rdy;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cyc_end) begin
      wait_cnt_d = '0;
    end else if (!cyc_final) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the external pad bus between the 6502 core and a DMA requester.
// Latency: bus mux is combinational; dma_ack/dma_rdata one clock after the DMA final clock.
// Backpressure: cpu_rdy=0 stalls the core; ext_rdy=0 stretches the final clock of any cycle.
// Ports: cpu_* core side, dma_* requester side, bus_* pad side, ext_rdy pad ready.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WAIT_CYCLES   = 1,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  input  logic        ext_rdy,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  output logic        bus_we,
  output logic        bus_oe
);

  logic cyc_final;
  logic cyc_end;

  owner_e             owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               dma_ack_q, dma_ack_d;
  logic [7:0]         dma_rdata_q, dma_rdata_d;
  logic [7:0]         cpu_di_hold_q, cpu_di_hold_d;

  logic own_dma;
  logic dma_grant;

  bus_cycle_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .ext_rdy  (ext_rdy),
    .cyc_final(cyc_final),
    .cyc_end  (cyc_end)
  );

  assign own_dma = (owner_q == OWN_DMA);

  // dma_req seen at the final clock of a DMA cycle is taken as the requester's
  // next request: it updates address/data in the ack clock, which is already
  // the address clock of the following cycle. The ack clock itself can only be
  // a boundary when WAIT_CYCLES=0; there the request still belongs to the
  // access being acked, so it is masked to avoid a double grant.
  assign dma_grant = dma_req && !dma_ack_q &&
                     (burst_cnt_q < BURST_W'(DMA_MAX_BURST));

  always_comb begin
    owner_d       = owner_q;
    burst_cnt_d   = burst_cnt_q;
    dma_ack_d     = own_dma && cyc_end;
    dma_rdata_d   = dma_rdata_q;
    cpu_di_hold_d = cpu_di_hold_q;

    if (cyc_end) begin
      if (dma_grant) begin
        owner_d     = OWN_DMA;
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end else begin
        owner_d     = OWN_CPU;
        burst_cnt_d = '0;
      end
    end

    if (own_dma && cyc_end && !dma_we) begin
      dma_rdata_d = bus_di;
    end

    // Keep the last word the core saw so cpu_di stays stable while DMA owns the bus.
    if (!own_dma && cyc_final) begin
      cpu_di_hold_d = bus_di;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q       <= OWN_CPU;
      burst_cnt_q   <= '0;
      dma_ack_q     <= 1'b0;
      dma_rdata_q   <= '0;
      cpu_di_hold_q <= '0;
    end else begin
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      dma_ack_q     <= dma_ack_d;
      dma_rdata_q   <= dma_rdata_d;
      cpu_di_hold_q <= cpu_di_hold_d;
    end
  end

  // Strobes are gated by reset_n so the pads go quiet the moment reset asserts,
  // independent of the still-muxed core inputs.
  assign bus_a     = own_dma ? dma_addr  : cpu_ab;
  assign bus_do    = own_dma ? dma_wdata : cpu_do;
  assign bus_we    = reset_n && (own_dma ? dma_we : cpu_we);
  assign bus_oe    = bus_we;
  assign cpu_rdy   = reset_n && !own_dma && cyc_end;
  assign cpu_di    = own_dma ? cpu_di_hold_q : bus_di;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances).
// DMA read data expectations are queued when stimulus is driven and popped on dma_ack.
// Inputs change 1ns after posedge; outputs are sampled on the falling edge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        ext_rdy;
  logic [15:0] bus_a;
  logic [7:0]  bus_do;
  logic [7:0]  bus_di;
  logic        bus_we;
  logic        bus_oe;

  logic        z_dma_req;
  logic        z_ext_rdy;
  logic [7:0]  z_cpu_di;
  logic        z_cpu_rdy;
  logic        z_dma_ack;
  logic [7:0]  z_dma_rdata;
  logic [15:0] z_bus_a;
  logic [7:0]  z_bus_do;
  logic        z_bus_we;
  logic        z_bus_oe;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_CYCLES(1), .DMA_MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .ext_rdy(ext_rdy),
    .bus_a(bus_a), .bus_do(bus_do), .bus_di(bus_di), .bus_we(bus_we), .bus_oe(bus_oe)
  );

  bus_arbiter #(.WAIT_CYCLES(0), .DMA_MAX_BURST(4)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(z_cpu_di), .cpu_rdy(z_cpu_rdy),
    .dma_req(z_dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_ack(z_dma_ack), .dma_rdata(z_dma_rdata), .ext_rdy(z_ext_rdy),
    .bus_a(z_bus_a), .bus_do(z_bus_do), .bus_di(bus_di), .bus_we(z_bus_we), .bus_oe(z_bus_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && dma_ack === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) check("ack_unexpected", {31'd0, dma_ack}, 32'd0);
      else check("ack_rdata", {24'd0, dma_rdata}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int   burst;
    int   ack0;
    logic exp_dma;

    reset_n   = 1'b0;
    cpu_ab    = 16'h1234;
    cpu_do    = 8'h99;
    cpu_we    = 1'b1;
    dma_req   = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    dma_we    = 1'b0;
    ext_rdy   = 1'b1;
    bus_di    = 8'hA5;
    z_dma_req = 1'b0;
    z_ext_rdy = 1'b1;

    // Reset state: strobes and RDY held low even with cpu_we=1.
    smp();
    check("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
    check("rst_dma_rdata", {24'd0, dma_rdata}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
    check("rst_z_cpu_rdy", {31'd0, z_cpu_rdy}, 32'd0);
    check("rst_z_bus_we", {31'd0, z_bus_we}, 32'd0);
    nxt();
    cpu_we  = 1'b0;
    reset_n = 1'b1;

    // CPU-only reads of 0x1234: RDY 0,1,0,1; WAIT_CYCLES=0 instance always ready.
    for (int i = 0; i < 4; i++) begin
      smp();
      check("t1_cpu_rdy", {31'd0, cpu_rdy}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("t1_bus_a", {16'd0, bus_a}, 32'h1234);
      check("t1_bus_we", {31'd0, bus_we}, 32'd0);
      if (i % 2 == 1) check("t1_cpu_di", {24'd0, cpu_di}, 32'hA5);
      check("t6_z_cpu_rdy", {31'd0, z_cpu_rdy}, 32'd1);
      check("t6_z_cpu_di", {24'd0, z_cpu_di}, 32'hA5);
      nxt();
    end

    // DMA write 0x0200<=0x5A raised in a CPU address clock.
    dma_req   = 1'b1;
    dma_addr  = 16'h0200;
    dma_wdata = 8'h5A;
    dma_we    = 1'b1;
    exp_q.push_back(8'h00);  // write ack: read data register keeps its reset value
    smp();
    check("t2_cpu_mid_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("t2_cpu_mid_a", {16'd0, bus_a}, 32'h1234);
    nxt();
    smp();
    check("t2_cpu_done", {31'd0, cpu_rdy}, 32'd1);
    nxt();
    bus_di = 8'h66;
    smp();
    check("t2_dma_a", {16'd0, bus_a}, 32'h0200);
    check("t2_dma_do", {24'd0, bus_do}, 32'h5A);
    check("t2_dma_we", {31'd0, bus_we}, 32'd1);
    check("t2_dma_oe", {31'd0, bus_oe}, 32'd1);
    check("t2_dma_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("t2_cpu_di_hold", {24'd0, cpu_di}, 32'hA5);
    check("t2_ack_early", {31'd0, dma_ack}, 32'd0);
    nxt();
    dma_req = 1'b0;  // dropped mid-cycle: the cycle must still complete and ack
    smp();
    check("t2_final_ack", {31'd0, dma_ack}, 32'd0);
    nxt();
    smp();
    check("t2_ack", {31'd0, dma_ack}, 32'd1);
    check("t2_back_cpu", {16'd0, bus_a}, 32'h1234);
    check("t2_back_we", {31'd0, bus_we}, 32'd0);
    nxt();
    dma_we   = 1'b0;
    dma_addr = 16'h0300;
    dma_req  = 1'b1;
    smp();
    check("t2_ack_pulse", {31'd0, dma_ack}, 32'd0);

    // Held request, burst limit 4: D,D,D,D,C,D,D,D,D,C with 8 acks.
    ack0  = ack_cnt;
    burst = 0;
    for (int c = 0; c < 10; c++) begin
      nxt();
      if (burst < 4) begin
        exp_dma = 1'b1;
        burst++;
      end else begin
        exp_dma = 1'b0;
        burst = 0;
      end
      bus_di = 8'h10 + 8'(c);
      smp();
      check("t3_owner", {31'd0, (bus_a == 16'h0300)}, {31'd0, exp_dma});
      nxt();
      bus_di = 8'hC0 + 8'(c);
      if (exp_dma) exp_q.push_back(bus_di);
      if (c == 9) dma_req = 1'b0;
      smp();
      check("t3_cpu_rdy", {31'd0, cpu_rdy}, {31'd0, !exp_dma});
    end
    check("t3_ack_count", ack_cnt - ack0, 32'd8);

    // DMA read of 0x8000 with ext_rdy low for 3 final clocks.
    nxt();
    dma_addr = 16'h8000;
    dma_req  = 1'b1;
    smp();
    check("t4_cpu_first", {16'd0, bus_a}, 32'h1234);
    nxt();
    smp();
    nxt();
    smp();
    check("t4_dma_a", {16'd0, bus_a}, 32'h8000);
    nxt();
    ext_rdy = 1'b0;
    bus_di  = 8'h77;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("t4_stall_a", {16'd0, bus_a}, 32'h8000);
      check("t4_stall_ack", {31'd0, dma_ack}, 32'd0);
      nxt();
    end
    ext_rdy = 1'b1;
    bus_di  = 8'h3C;
    exp_q.push_back(8'h3C);
    dma_req = 1'b0;
    smp();
    check("t4_final_ack", {31'd0, dma_ack}, 32'd0);
    nxt();
    bus_di = 8'h11;
    smp();
    check("t4_ack", {31'd0, dma_ack}, 32'd1);
    check("t4_rdata", {24'd0, dma_rdata}, 32'h3C);
    nxt();
    smp();

    // Reset in the middle of a DMA write: abandoned, no ack, CPU owns afterwards.
    nxt();
    dma_addr  = 16'h0400;
    dma_wdata = 8'hE7;
    dma_we    = 1'b1;
    dma_req   = 1'b1;
    smp();
    nxt();
    smp();
    nxt();
    smp();
    check("t5_dma_we", {31'd0, bus_we}, 32'd1);
    nxt();
    ack0    = ack_cnt;
    reset_n = 1'b0;
    dma_req = 1'b0;
    #1;
    check("t5_rst_we", {31'd0, bus_we}, 32'd0);
    check("t5_rst_oe", {31'd0, bus_oe}, 32'd0);
    check("t5_rst_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("t5_rst_ack", {31'd0, dma_ack}, 32'd0);
    check("t5_rst_rdata", {24'd0, dma_rdata}, 32'd0);
    nxt();
    nxt();
    reset_n = 1'b1;
    smp();
    check("t5_cpu_first", {16'd0, bus_a}, 32'h1234);
    check("t5_first_rdy", {31'd0, cpu_rdy}, 32'd0);
    nxt();
    smp();
    check("t5_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
    nxt();
    smp();
    nxt();
    smp();
    check("t5_no_ack", ack_cnt - ack0, 32'd0);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
